// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue/writeback sequencer: opcodes,
// FSM state encoding and default datapath geometry.
package alu_issue_pkg;

  // Default geometry; the ALU is 8 bits wide with 8 architectural registers.
  localparam int DW_DEF    = 8;
  localparam int NREGS_DEF = 8;
  localparam int AW_DEF    = 3;

  // ALU opcodes as understood by the downstream registered ALU.
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_NOR = 3'b110;

  // Sequencer states: wait for an instruction, let the ALU compute, write back.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

endpackage

// File: rtl/alu_regfile.sv
// Architectural register file for the ALU sequencer: two combinational
// operand read ports, one debug read port and one synchronous write port.
// Register 0 is hardwired to zero; writes addressed to it are dropped.
module alu_regfile
  import alu_issue_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b,
  input  logic [AW-1:0] dbg_raddr,
  output logic [DW-1:0] dbg_rdata
);

  logic [DW-1:0] regs [NREGS];

  // Storage: cleared on reset, written on we unless the target is R0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports force R0 to zero so the hardwired value never depends on storage.
  always_comb begin
    rdata_a   = (raddr_a   == '0) ? '0 : regs[raddr_a];
    rdata_b   = (raddr_b   == '0) ? '0 : regs[raddr_b];
    dbg_rdata = (dbg_raddr == '0) ? '0 : regs[dbg_raddr];
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Operand-issue and writeback sequencer wrapped around a registered ALU.
// One instruction is accepted at a time: operands are read and presented
// to the ALU, the ALU result arrives one cycle later and is written back
// with status flags, giving one instruction every three cycles.
// Optional feature macro: ALU_ISSUE_IMM_EN adds an immediate B operand.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [2:0]    instr_op,
  input  logic [AW-1:0] instr_rd,
  input  logic [AW-1:0] instr_rs1,
  input  logic [AW-1:0] instr_rs2,
`ifdef ALU_ISSUE_IMM_EN
  input  logic          instr_imm_sel,
  input  logic [DW-1:0] instr_imm,
`endif
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_op,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_carry,
  input  logic          alu_overflow,
  output logic          done,
  output logic          flag_z,
  output logic          flag_c,
  output logic          flag_v,
  input  logic [AW-1:0] dbg_raddr,
  output logic [DW-1:0] dbg_rdata
);

  state_t        state;
  logic [AW-1:0] rd_q;
  logic [DW-1:0] rs1_data;
  logic [DW-1:0] rs2_data;
  logic [DW-1:0] b_operand;
  logic          accept;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  // A preload in IDLE wins over an instruction so the two never collide on the write port.
  assign instr_ready = (state == S_IDLE) && !wr_en;
  assign accept      = instr_valid && instr_ready;

  // B operand source: register rs2, or the immediate when that feature is built in.
`ifdef ALU_ISSUE_IMM_EN
  always_comb begin
    b_operand = instr_imm_sel ? instr_imm : rs2_data;
  end
`else
  always_comb begin
    b_operand = rs2_data;
  end
`endif

  // Single write port shared by writeback (in WB) and preload (only honoured in IDLE).
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = wr_addr;
    rf_wdata = wr_data;
    if (state == S_WB) begin
      rf_we    = 1'b1;
      rf_waddr = rd_q;
      rf_wdata = alu_result;
    end else if ((state == S_IDLE) && wr_en) begin
      rf_we    = 1'b1;
    end
  end

  alu_regfile #(
    .DW    (DW),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we        (rf_we),
    .waddr     (rf_waddr),
    .wdata     (rf_wdata),
    .raddr_a   (instr_rs1),
    .rdata_a   (rs1_data),
    .raddr_b   (instr_rs2),
    .rdata_b   (rs2_data),
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata)
  );

  // Sequencer FSM with registered ALU drive, destination latch, flags and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      rd_q   <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      done   <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            alu_a  <= rs1_data;
            alu_b  <= b_operand;
            alu_op <= instr_op;
            rd_q   <= instr_rd;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          state <= S_WB;
        end
        S_WB: begin
          // The ALU's own zero output lags a cycle, so zero is derived from the result here.
          flag_z <= (alu_result == '0);
          flag_c <= alu_carry;
          flag_v <= alu_overflow;
          done   <= 1'b1;
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
